v_inst_queue: RTL and testbench

- Decoupling FIFO directly upstream of the vector core top.
- Accepts vector instructions, plus the scalar rs1 value captured at dispatch time, from the scalar pipeline.
- Issues them in order, one per handshake, into the vector core's inst / rs1 inputs.
- Tracks queued instructions that will write a scalar rd, so the scalar pipeline can interlock on them.

---
 rtl/v_inst_queue.sv | 113 +++++++++++
 tb/tb_v_inst_queue.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/v_inst_queue.sv
// In-order decoupling queue between the scalar pipeline and the vector core.
// Tracks queued entries that will write a scalar rd for interlocking.
module v_inst_queue #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 32,
  parameter int SREG_W = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enq_valid_i,
  output logic                     enq_ready_o,
  input  logic [INST_W-1:0]        enq_inst_i,
  input  logic [SREG_W-1:0]        enq_rs1_data_i,
  input  logic                     flush_i,
  output logic                     issue_valid_o,
  input  logic                     issue_ready_i,
  output logic [INST_W-1:0]        issue_inst_o,
  output logic [SREG_W-1:0]        issue_rs1_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     scalar_wb_pending_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [6:0] OP_V = 7'b1010111;

  logic [INST_W-1:0] mem_inst [DEPTH];
  logic [SREG_W-1:0] mem_rs1  [DEPTH];
  logic [DEPTH-1:0]  mem_swb;

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] swb_cnt;

  logic enq_fire;
  logic iss_fire;
  logic enq_is_swb;
  logic enq_swb;
  logic iss_swb;

  assign full_o        = (count == CW'(DEPTH));
  assign empty_o       = (count == '0);
  assign enq_ready_o   = !full_o;
  assign issue_valid_o = !empty_o;
  assign count_o       = count;

  assign enq_fire = enq_valid_i && enq_ready_o;
  assign iss_fire = issue_valid_o && issue_ready_i;

  assign issue_inst_o     = empty_o ? '0 : mem_inst[rd_ptr];
  assign issue_rs1_data_o = empty_o ? '0 : mem_rs1[rd_ptr];

  assign scalar_wb_pending_o = (swb_cnt != '0);

  // vsetvl/vsetvli and vmv.x.s are the OP-V forms that write a scalar rd
  always_comb begin
    enq_is_swb = 1'b0;
    if (enq_inst_i[6:0] == OP_V) begin
      unique case (1'b1)
        (enq_inst_i[14:12] == 3'b111):
          enq_is_swb = 1'b1;
        (enq_inst_i[14:12] == 3'b010):
          enq_is_swb = (enq_inst_i[31:26] == 6'b010000);
        default:
          enq_is_swb = 1'b0;
      endcase
    end
  end

  assign enq_swb = enq_fire && enq_is_swb;
  assign iss_swb = iss_fire && mem_swb[rd_ptr];

  always_ff @(posedge clk) begin
    if (enq_fire) begin
      mem_inst[wr_ptr] <= enq_inst_i;
      mem_rs1[wr_ptr]  <= enq_rs1_data_i;
      mem_swb[wr_ptr]  <= enq_is_swb;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      swb_cnt <= '0;
    end else if (flush_i) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      swb_cnt <= '0;
    end else begin
      if (enq_fire)
        wr_ptr <= wr_ptr + AW'(1);
      if (iss_fire)
        rd_ptr <= rd_ptr + AW'(1);
      unique case ({enq_fire, iss_fire})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      unique case ({enq_swb, iss_swb})
        2'b10:   swb_cnt <= swb_cnt + CW'(1);
        2'b01:   swb_cnt <= swb_cnt - CW'(1);
        default: swb_cnt <= swb_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_v_inst_queue.sv
// Scoreboard bench for v_inst_queue.
// Negedge monitor compares the head and status against a queue model.
module tb_v_inst_queue;

  localparam int DEPTH  = 4;
  localparam int INST_W = 32;
  localparam int SREG_W = 64;

  typedef struct {
    logic [INST_W-1:0] inst;
    logic [SREG_W-1:0] rs1;
    logic              swb;
  } ent_t;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   enq_valid_i;
  logic                   enq_ready_o;
  logic [INST_W-1:0]      enq_inst_i;
  logic [SREG_W-1:0]      enq_rs1_data_i;
  logic                   flush_i;
  logic                   issue_valid_o;
  logic                   issue_ready_i;
  logic [INST_W-1:0]      issue_inst_o;
  logic [SREG_W-1:0]      issue_rs1_data_o;
  logic [$clog2(DEPTH):0] count_o;
  logic                   full_o;
  logic                   empty_o;
  logic                   scalar_wb_pending_o;

  int n_chk = 0;
  int n_err = 0;
  ent_t sb[$];

  v_inst_queue #(
    .DEPTH (DEPTH),
    .INST_W(INST_W),
    .SREG_W(SREG_W)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .enq_valid_i        (enq_valid_i),
    .enq_ready_o        (enq_ready_o),
    .enq_inst_i         (enq_inst_i),
    .enq_rs1_data_i     (enq_rs1_data_i),
    .flush_i            (flush_i),
    .issue_valid_o      (issue_valid_o),
    .issue_ready_i      (issue_ready_i),
    .issue_inst_o       (issue_inst_o),
    .issue_rs1_data_o   (issue_rs1_data_o),
    .count_o            (count_o),
    .full_o             (full_o),
    .empty_o            (empty_o),
    .scalar_wb_pending_o(scalar_wb_pending_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  function automatic logic is_swb(input logic [31:0] i);
    logic [6:0] op;
    logic [2:0] f3;
    logic [5:0] f6;
    op = i[6:0];
    f3 = i[14:12];
    f6 = i[31:26];
    return (op == 7'h57) &&
           ((f3 == 3'b111) || (f3 == 3'b010 && f6 == 6'b010000));
  endfunction

  // Model: status and head must reflect the queue before this edge
  always @(negedge clk) begin
    logic pend;
    logic do_iss;
    logic do_enq;
    ent_t e;
    if (!rst) begin
      sb.delete();
    end else begin
      pend = 1'b0;
      foreach (sb[k]) pend |= sb[k].swb;
      chk("count", 64'(count_o), 64'(sb.size()));
      chk("full", 64'(full_o), 64'(sb.size() == DEPTH));
      chk("empty", 64'(empty_o), 64'(sb.size() == 0));
      chk("enq_ready", 64'(enq_ready_o), 64'(sb.size() < DEPTH));
      chk("issue_valid", 64'(issue_valid_o), 64'(sb.size() > 0));
      chk("swb_pend", 64'(scalar_wb_pending_o), 64'(pend));
      chk("cnt_le_depth", 64'(count_o <= DEPTH), 64'd1);
      assert (dut.swb_cnt <= dut.count_o);
      if (sb.size() > 0) begin
        chk("head_inst", 64'(issue_inst_o), 64'(sb[0].inst));
        chk("head_rs1", issue_rs1_data_o, sb[0].rs1);
      end else begin
        chk("idle_inst", 64'(issue_inst_o), 64'd0);
        chk("idle_rs1", issue_rs1_data_o, 64'd0);
      end
      if (flush_i) begin
        sb.delete();
      end else begin
        do_iss = issue_ready_i && (sb.size() > 0);
        do_enq = enq_valid_i && (sb.size() < DEPTH);
        if (do_iss)
          void'(sb.pop_front());
        if (do_enq) begin
          e.inst = enq_inst_i;
          e.rs1  = enq_rs1_data_i;
          e.swb  = is_swb(enq_inst_i);
          sb.push_back(e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] i, input logic [63:0] r);
    enq_valid_i    = 1'b1;
    enq_inst_i     = i;
    enq_rs1_data_i = r;
    step();
    enq_valid_i    = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_empty"}, 64'(empty_o), 64'd1);
    chk({tag, "_full"}, 64'(full_o), 64'd0);
    chk({tag, "_ready"}, 64'(enq_ready_o), 64'd1);
    chk({tag, "_valid"}, 64'(issue_valid_o), 64'd0);
    chk({tag, "_count"}, 64'(count_o), 64'd0);
    chk({tag, "_pend"}, 64'(scalar_wb_pending_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    logic [31:0] fill [4];
    fill[0] = 32'h02008057;
    fill[1] = 32'h0200A0D7;
    fill[2] = 32'h02010157;
    fill[3] = 32'h020181D7;

    rst            = 1'b0;
    enq_valid_i    = 1'b0;
    enq_inst_i     = '0;
    enq_rs1_data_i = '0;
    flush_i        = 1'b0;
    issue_ready_i  = 1'b0;
    repeat (2) step();
    rst = 1'b1;
    chk_reset("rst");
    step();
    chk_reset("idle");

    // fill, refuse a fifth, then drain in order
    for (int i = 0; i < 4; i++)
      enq(fill[i], 64'(32'h10 + i));
    chk("fill_full", 64'(full_o), 64'd1);
    chk("fill_ready", 64'(enq_ready_o), 64'd0);
    enq(32'hDEADBEEF, 64'h99);
    chk("fifth_count", 64'(count_o), 64'd4);
    chk("fifth_head", 64'(issue_inst_o), 64'h02008057);
    issue_ready_i = 1'b1;
    repeat (4) step();
    chk("drain_empty", 64'(empty_o), 64'd1);
    issue_ready_i = 1'b0;

    // streaming across pointer wrap
    issue_ready_i = 1'b1;
    chk("stream_pre_valid", 64'(issue_valid_o), 64'd0);
    for (int i = 0; i < 10; i++) begin
      enq_valid_i    = 1'b1;
      enq_inst_i     = 32'h02000057 | (32'(i) << 15);
      enq_rs1_data_i = 64'h100 + 64'(i);
      step();
      chk("stream_count", 64'(count_o), 64'd1);
      chk("stream_valid", 64'(issue_valid_o), 64'd1);
    end
    enq_valid_i = 1'b0;
    step();
    chk("stream_empty", 64'(empty_o), 64'd1);
    issue_ready_i = 1'b0;

    // scalar writeback tracking
    enq(32'h0C0572D7, 64'h1);
    chk("swb_first", 64'(scalar_wb_pending_o), 64'd1);
    enq(32'h42002557, 64'h2);
    issue_ready_i = 1'b1;
    step();
    chk("swb_one_left", 64'(scalar_wb_pending_o), 64'd1);
    step();
    chk("swb_none", 64'(scalar_wb_pending_o), 64'd0);
    issue_ready_i = 1'b0;

    // flush beats simultaneous enqueue and issue
    enq(32'h0C0572D7, 64'h21);
    enq(fill[1], 64'h22);
    enq(fill[2], 64'h23);
    chk("pre_flush_count", 64'(count_o), 64'd3);
    flush_i        = 1'b1;
    enq_valid_i    = 1'b1;
    enq_inst_i     = 32'h0C0BAD57;
    enq_rs1_data_i = 64'hBAD;
    issue_ready_i  = 1'b1;
    step();
    flush_i     = 1'b0;
    enq_valid_i = 1'b0;
    chk("flush_count", 64'(count_o), 64'd0);
    chk("flush_valid", 64'(issue_valid_o), 64'd0);
    chk("flush_pend", 64'(scalar_wb_pending_o), 64'd0);
    repeat (3) step();
    issue_ready_i = 1'b0;

    // reset while issuing
    enq(32'h42002557, 64'h31);
    enq(fill[3], 64'h32);
    issue_ready_i = 1'b1;
    rst = 1'b0;
    step();
    rst = 1'b1;
    chk_reset("midrst");
    repeat (3) step();
    chk("midrst_still_empty", 64'(issue_valid_o), 64'd0);
    issue_ready_i = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
